boost_pwm_gen: RTL and testbench

- Parametrised successor of the single-channel boost PWM block.
- Generates N_CH complementary PWM pairs with programmable dead time from one system clock, using a clock-enable tick instead of a derived clock.
- Duty values are double-buffered and take effect only at the period boundary.
- Also produces the periodic control-loop interrupt square wave and a one-cycle interrupt strobe.

---
 rtl/boost_pkg.sv | 27 ++
 rtl/pwm_dt_channel.sv | 91 +++++++++
 rtl/boost_pwm_gen.sv | 110 +++++++++++
 tb/tb_boost_pwm_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boost_pkg.sv
// rtl/boost_pkg.sv - shared types, default constants and width helper for the boost PWM generator
//
// Contents:
//   ch_state_e  - complementary channel state (ST_OFF, ST_ON, ST_DEAD)
//   PWM_*       - default generator parameters (10-bit carrier, 4 us tick at 100 MHz)
//   clog2w()    - counter width that never collapses to zero bits

package boost_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ON   = 2'd1,
        ST_DEAD = 2'd2
    } ch_state_e;

    localparam int PWM_DW      = 10;
    localparam int PWM_PRESC   = 400;
    localparam int PWM_DT      = 4;
    localparam int INT_DIV_DEF = 500;

    // Width needed to hold 0..value-1; at least one bit so degenerate
    // parameter choices still give legal vectors.
    function automatic int clog2w(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/pwm_dt_channel.sv
// rtl/pwm_dt_channel.sv - one complementary gate pair with dead-time insertion
//
// Ports:
//   clk, rst  - system clock, asynchronous active-high reset
//   ce        - run enable; low forces the pair into dead time
//   tick      - one-clk PWM time base strobe
//   raw       - compare result for the upcoming carrier value
//   s, nots   - registered high-side / low-side gate drive

module pwm_dt_channel
    import boost_pkg::*;
#(
    parameter int DT = PWM_DT
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic tick,
    input  logic raw,
    output logic s,
    output logic nots
);

    localparam int              DTW   = clog2w(DT + 1);
    localparam logic [DTW-1:0]  DT_LD = DTW'(DT);

    ch_state_e        state_q;
    logic [DTW-1:0]   dcnt_q;
    logic             raw_q;
    logic             s_q;
    logic             nots_q;

    // Gate outputs are decided together with the state, so s and nots come
    // from one registered decision and can never be high together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DEAD;
            dcnt_q  <= DT_LD;
            raw_q   <= 1'b0;
            s_q     <= 1'b0;
            nots_q  <= 1'b0;
        end else begin
            raw_q <= raw;
            if (!ce) begin
                state_q <= ST_DEAD;
                dcnt_q  <= DT_LD;
                s_q     <= 1'b0;
                nots_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_ON: begin
                        if (!raw) begin
                            state_q <= ST_DEAD;
                            dcnt_q  <= DT_LD;
                            s_q     <= 1'b0;
                        end
                    end
                    ST_OFF: begin
                        if (raw) begin
                            state_q <= ST_DEAD;
                            dcnt_q  <= DT_LD;
                            nots_q  <= 1'b0;
                        end
                    end
                    default: begin
                        s_q    <= 1'b0;
                        nots_q <= 1'b0;
                        // A compare edge inside the dead window restarts it,
                        // which is what swallows pulses shorter than DT.
                        if (raw != raw_q) begin
                            dcnt_q <= DT_LD;
                        end else if (tick) begin
                            if (dcnt_q == DTW'(1)) begin
                                dcnt_q  <= '0;
                                state_q <= raw ? ST_ON : ST_OFF;
                                s_q     <= raw;
                                nots_q  <= !raw;
                            end else begin
                                dcnt_q <= dcnt_q - 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign s    = s_q;
    assign nots = nots_q;

endmodule

// File: rtl/boost_pwm_gen.sv
// rtl/boost_pwm_gen.sv - N-channel complementary boost PWM with dead time and control-loop interrupt
//
// Ports:
//   clk, rst      - system clock, asynchronous active-high reset
//   ce            - run enable; 0 = safe stop (gates off, counters hold)
//   d_pwm         - duty words, channel k at [k*DW +: DW], sampled at carrier wrap
//   pwm_s         - high-side gate drive per channel
//   pwm_nots      - low-side gate drive per channel
//   clk_int       - interrupt square wave, high for the first half of INT_DIV ticks
//   int_pulse     - one-clk strobe on clk_int rising edge
//   period_start  - one-clk strobe when the carrier wraps to 0

module boost_pwm_gen
    import boost_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int DW      = PWM_DW,
    parameter int PRESC   = PWM_PRESC,
    parameter int DT      = PWM_DT,
    parameter int INT_DIV = INT_DIV_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [N_CH*DW-1:0]   d_pwm,
    output logic [N_CH-1:0]      pwm_s,
    output logic [N_CH-1:0]      pwm_nots,
    output logic                 clk_int,
    output logic                 int_pulse,
    output logic                 period_start
);

    localparam int PW = clog2w(PRESC);
    localparam int IW = clog2w(INT_DIV);

    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [DW-1:0]       cnt_q, cnt_d;
    logic [N_CH*DW-1:0]  shadow_q, shadow_d;
    logic [IW-1:0]       icnt_q, icnt_d;
    logic                clk_int_q, clk_int_d;
    logic                int_pulse_q;
    logic                period_start_q;
    logic                tick;
    logic                wrap;
    logic                iwrap;
    logic [N_CH-1:0]     raw;

    always_comb begin
        tick   = ce && (pcnt_q == PW'(PRESC - 1));
        pcnt_d = pcnt_q;
        if (ce) begin
            pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        end

        wrap     = tick && (cnt_q == {DW{1'b1}});
        cnt_d    = tick ? cnt_q + 1'b1 : cnt_q;
        shadow_d = wrap ? d_pwm : shadow_q;

        iwrap  = tick && (icnt_q == IW'(INT_DIV - 1));
        icnt_d = icnt_q;
        if (tick) begin
            icnt_d = iwrap ? '0 : icnt_q + 1'b1;
        end
        clk_int_d = ce ? (icnt_d < IW'(INT_DIV / 2)) : clk_int_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q         <= '0;
            cnt_q          <= '0;
            shadow_q       <= '0;
            icnt_q         <= '0;
            clk_int_q      <= 1'b0;
            int_pulse_q    <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            pcnt_q         <= pcnt_d;
            cnt_q          <= cnt_d;
            shadow_q       <= shadow_d;
            icnt_q         <= icnt_d;
            clk_int_q      <= clk_int_d;
            int_pulse_q    <= iwrap;
            period_start_q <= wrap;
        end
    end

    // The compare looks at the carrier and shadow values being loaded this
    // cycle, so a wrap and its new duty land on the gates one clk after the
    // tick, the same cycle period_start is seen.
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign raw[k] = cnt_d < shadow_d[k*DW +: DW];

        pwm_dt_channel #(
            .DT (DT)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .ce   (ce),
            .tick (tick),
            .raw  (raw[k]),
            .s    (pwm_s[k]),
            .nots (pwm_nots[k])
        );
    end

    assign clk_int      = clk_int_q;
    assign int_pulse    = int_pulse_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_boost_pwm_gen.sv
// tb/tb_boost_pwm_gen.sv - scoreboard bench for boost_pwm_gen with small parameters

module tb_boost_pwm_gen;

    localparam int N_CH    = 2;
    localparam int DW      = 4;
    localparam int PRESC   = 4;
    localparam int DT      = 2;
    localparam int INT_DIV = 10;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                ce  = 1'b1;
    logic [N_CH*DW-1:0]  d_pwm = '0;
    logic [N_CH-1:0]     pwm_s;
    logic [N_CH-1:0]     pwm_nots;
    logic                clk_int;
    logic                int_pulse;
    logic                period_start;

    always #5 clk = ~clk;

    boost_pwm_gen #(
        .N_CH    (N_CH),
        .DW      (DW),
        .PRESC   (PRESC),
        .DT      (DT),
        .INT_DIV (INT_DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .d_pwm        (d_pwm),
        .pwm_s        (pwm_s),
        .pwm_nots     (pwm_nots),
        .clk_int      (clk_int),
        .int_pulse    (int_pulse),
        .period_start (period_start)
    );

    // Expected high-clk counts per carrier period (64 clk) for each gate.
    typedef struct {
        int idx;
        int s0;
        int n0;
        int s1;
        int n1;
    } exp_t;

    exp_t sbq[$];
    int   total   = 0;
    int   bad     = 0;
    int   pidx    = 0;
    bit   win_open = 1'b0;
    int   acc_s0 = 0, acc_n0 = 0, acc_s1 = 0, acc_n1 = 0;
    int   overlap = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic close_window(input int w);
        exp_t e;
        while (sbq.size() > 0 && sbq[0].idx < w) begin
            e = sbq.pop_front();
            total++;
            bad++;
            $display("FAIL sb_window_missed: window %0d never closed (now %0d)", e.idx, w);
        end
        if (sbq.size() > 0 && sbq[0].idx == w) begin
            e = sbq.pop_front();
            chk($sformatf("win%0d_s0", w), acc_s0, e.s0);
            chk($sformatf("win%0d_nots0", w), acc_n0, e.n0);
            chk($sformatf("win%0d_s1", w), acc_s1, e.s1);
            chk($sformatf("win%0d_nots1", w), acc_n1, e.n1);
        end
    endtask

    // Monitor: a window runs from one period_start sample to the next.
    always @(negedge clk) begin
        if (period_start === 1'b1) begin
            if (win_open) close_window(pidx);
            pidx++;
            win_open = 1'b1;
            acc_s0 = 0; acc_n0 = 0; acc_s1 = 0; acc_n1 = 0;
        end
        acc_s0 += int'(pwm_s[0]);
        acc_n0 += int'(pwm_nots[0]);
        acc_s1 += int'(pwm_s[1]);
        acc_n1 += int'(pwm_nots[1]);
        if ((pwm_s & pwm_nots) != '0) overlap++;
    end

    task automatic push(input int s0, input int n0, input int s1, input int n1);
        exp_t e;
        e.idx = pidx; e.s0 = s0; e.n0 = n0; e.s1 = s1; e.n1 = n1;
        sbq.push_back(e);
    endtask

    task automatic wait_ps();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (period_start === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL period_start_timeout: got none expected strobe within 300 clk");
        end
    endtask

    task automatic check_int();
        bit found;
        int n;
        int m;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #1;
            if (int_pulse === 1'b1) found = 1'b1;
        end
        chk("int_pulse_seen", int'(found), 1);
        if (found) begin
            chk("int_pulse_on_rise", int'(clk_int), 1);
            n = 0;
            do begin
                n++;
                @(negedge clk);
                #1;
                if (n == 1) chk("int_pulse_width", int'(int_pulse), 0);
            end while (clk_int === 1'b1 && n < 100);
            chk("clk_int_high_clk", n, 20);
            m = 0;
            while (clk_int === 1'b0 && m < 100) begin
                m++;
                @(negedge clk);
                #1;
            end
            chk("clk_int_low_clk", m, 20);
            chk("int_pulse_next_rise", int'(int_pulse), 1);
        end
    endtask

    initial begin
        logic lvl;
        int   viol;

        rst = 1'b1;
        ce  = 1'b1;
        d_pwm = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({pwm_s, pwm_nots, clk_int, int_pulse, period_start}), 0);
        rst = 1'b0;
        d_pwm = {4'd12, 4'd4};

        // Carrier at 5 in the first loaded period: ch1 on, ch0 in dead time.
        repeat (84) @(posedge clk);
        @(negedge clk);
        #1;
        chk("pre_reset_s", int'(pwm_s), 2);
        chk("pre_reset_nots", int'(pwm_nots), 0);
        chk("pre_reset_clk_int", int'(clk_int), 1);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", int'({pwm_s, pwm_nots, clk_int, int_pulse, period_start}), 0);
        d_pwm = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            if (i == 7) chk("dead_after_reset_nots", int'(pwm_nots), 0);
            if (i == 8) begin
                chk("off_after_reset_nots", int'(pwm_nots), 3);
                chk("off_after_reset_s", int'(pwm_s), 0);
            end
        end

        d_pwm = {4'd12, 4'd4};
        wait_ps(); push(8, 40, 40, 8);
        wait_ps(); push(8, 40, 40, 8);
        repeat (20) @(negedge clk);
        d_pwm = {4'd8, 4'd8};              // mid-period write at carrier 5
        wait_ps(); push(24, 24, 24, 24);
        d_pwm = {4'd0, 4'd1};
        wait_ps(); push(0, 52, 0, 64);
        d_pwm = {4'd3, 4'd15};
        wait_ps(); push(52, 0, 4, 44);
        d_pwm = {4'd13, 4'd2};
        wait_ps(); push(0, 48, 44, 4);
        d_pwm = {4'd12, 4'd4};
        wait_ps(); push(8, 40, 40, 8);

        // Safe stop while both high-side gates are on (carrier 2).
        wait_ps();
        repeat (10) @(negedge clk);
        #1;
        chk("ce_pre_s", int'(pwm_s), 3);
        chk("ce_pre_nots", int'(pwm_nots), 0);
        lvl = clk_int;
        ce = 1'b0;
        @(negedge clk);
        #1;
        chk("ce_off_gates", int'({pwm_s, pwm_nots}), 0);
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            #1;
            if (pwm_s != '0 || pwm_nots != '0 || period_start || int_pulse || clk_int != lvl) viol++;
        end
        chk("ce_off_hold", viol, 0);
        ce = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            #1;
            if (k == 5) chk("ce_resume_dead", int'({pwm_s, pwm_nots}), 0);
            if (k == 6) begin
                chk("ce_resume_s", int'(pwm_s), 2);
                chk("ce_resume_nots", int'(pwm_nots), 0);
            end
        end

        wait_ps(); push(8, 40, 40, 8);
        check_int();
        wait_ps();
        repeat (2) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        chk("no_gate_overlap", overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
